// File: rtl/io_map_pkg.sv
// Shared address map and bit layout for the memory-mapped KEY/SW input window.
// Also provides the register decoder used by the controller's read mux and write logic.
package io_map_pkg;

  localparam logic [15:0] ADDR_KDATA = 16'hFFF0;
  localparam logic [15:0] ADDR_SDATA = 16'hFFF2;
  localparam logic [15:0] ADDR_KCTRL = 16'hFFF4;
  localparam logic [15:0] ADDR_SCTRL = 16'hFFF6;

  localparam int KRDY_LSB = 0;
  localparam int KOVR_LSB = 4;
  localparam int SRDY_BIT = 0;
  localparam int SOVR_BIT = 1;

  localparam logic [3:0] KEY_IDLE = 4'hF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_KDATA,
    SEL_SDATA,
    SEL_KCTRL,
    SEL_SCTRL
  } reg_sel_e;

  function automatic reg_sel_e decode(input logic [15:0] addr);
    case (addr)
      ADDR_KDATA: return SEL_KDATA;
      ADDR_SDATA: return SEL_SDATA;
      ADDR_KCTRL: return SEL_KCTRL;
      ADDR_SCTRL: return SEL_SCTRL;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One-bit two-flop synchroniser followed by a counting debouncer.
// rise/fall are high during the cycle whose closing edge updates level.
module io_debounce #(
  parameter int   DEBCYC  = 500000,
  parameter int   CBITS   = 19,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic             sync1;
  logic             sync2;
  logic [CBITS-1:0] cnt;
  logic             settle;

  assign settle = (sync2 != level) && (cnt == CBITS'(DEBCYC - 1));
  assign rise   = settle & sync2;
  assign fall   = settle & ~sync2;

  // NOTE: every flop here uses <= so all state samples pre-edge values; blocking
  // assignments would let sync2 see this edge's sync1 and collapse the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
      level <= RST_VAL;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == level || settle) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CBITS'(1);
      end
      if (settle) begin
        level <= sync2;
      end
    end
  end

endmodule

// File: rtl/io_keysw_ctrl.sv
// Memory-mapped KEY/SW input controller: debounced data registers plus sticky
// write-1-to-clear RDY/OVR event status, read combinationally at 0xFFF0-0xFFF6.
module io_keysw_ctrl #(
  parameter int DBITS  = 16,
  parameter int DEBCYC = 500000,
  parameter int CBITS  = 19
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [15:0]      ADDR,
  input  logic [DBITS-1:0] WRDATA,
  input  logic             WE,
  output logic [DBITS-1:0] RDDATA,
  output logic             HIT,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW
);
  import io_map_pkg::*;

  logic [3:0] key_db, key_fall, key_rise_unused;
  logic [9:0] sw_db, sw_rise, sw_fall;

  for (genvar i = 0; i < 4; i++) begin : g_key
    io_debounce #(.DEBCYC(DEBCYC), .CBITS(CBITS), .RST_VAL(KEY_IDLE[i])) u_db (
      .clk(CLK), .rst_n(RSTN), .din(KEY[i]),
      .level(key_db[i]), .rise(key_rise_unused[i]), .fall(key_fall[i])
    );
  end

  for (genvar i = 0; i < 10; i++) begin : g_sw
    io_debounce #(.DEBCYC(DEBCYC), .CBITS(CBITS), .RST_VAL(1'b0)) u_db (
      .clk(CLK), .rst_n(RSTN), .din(SW[i]),
      .level(sw_db[i]), .rise(sw_rise[i]), .fall(sw_fall[i])
    );
  end

  reg_sel_e   sel;
  logic [3:0] krdy, kovr, krdy_clr, kovr_clr, krdy_keep;
  logic       srdy, sovr, srdy_clr, sovr_clr, srdy_keep, sw_event;
  logic       unused_wrdata;

  assign sel      = decode(ADDR);
  assign krdy_clr = (WE && sel == SEL_KCTRL) ? WRDATA[KRDY_LSB +: 4] : 4'h0;
  assign kovr_clr = (WE && sel == SEL_KCTRL) ? WRDATA[KOVR_LSB +: 4] : 4'h0;
  assign srdy_clr = WE && sel == SEL_SCTRL && WRDATA[SRDY_BIT];
  assign sovr_clr = WE && sel == SEL_SCTRL && WRDATA[SOVR_BIT];
  assign sw_event = |(sw_rise | sw_fall);
  assign unused_wrdata = ^WRDATA[DBITS-1:8];

  // Overrun looks at RDY only after this edge's clear, so a press landing on
  // its own W1C re-arms RDY without flagging an overrun; sets beat clears.
  assign krdy_keep = krdy & ~krdy_clr;
  assign srdy_keep = srdy & ~srdy_clr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      krdy <= '0;
      kovr <= '0;
      srdy <= 1'b0;
      sovr <= 1'b0;
    end else begin
      krdy <= krdy_keep | key_fall;
      kovr <= (kovr & ~kovr_clr) | (key_fall & krdy_keep);
      srdy <= srdy_keep | sw_event;
      sovr <= (sovr & ~sovr_clr) | (sw_event & srdy_keep);
    end
  end

  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    RDDATA = '0;
    HIT    = 1'b1;
    case (sel)
      SEL_KDATA: RDDATA[3:0] = key_db;
      SEL_SDATA: RDDATA[9:0] = sw_db;
      SEL_KCTRL: RDDATA[7:0] = {kovr, krdy};
      SEL_SCTRL: RDDATA[1:0] = {sovr, srdy};
      default:   HIT = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_io_keysw_ctrl.sv
// Scoreboarded bench for io_keysw_ctrl: directed scenarios plus random KEY/SW/W1C
// traffic, checked against a sample-history reference model of the input rules.
module tb_io_keysw_ctrl;

  localparam int DEBCYC = 4;
  localparam int CBITS  = 2;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [15:0] ADDR, WRDATA, RDDATA;
  logic        WE, HIT;
  logic [3:0]  KEY;
  logic [9:0]  SW;

  io_keysw_ctrl #(.DBITS(16), .DEBCYC(DEBCYC), .CBITS(CBITS)) dut (
    .CLK(CLK), .RSTN(RSTN), .ADDR(ADDR), .WRDATA(WRDATA), .WE(WE),
    .RDDATA(RDDATA), .HIT(HIT), .KEY(KEY), .SW(SW)
  );

  always #20 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a level is accepted once the last DEBCYC synchronised
  // samples (raw input delayed two edges) all agree and differ from it.
  typedef struct packed {
    logic [3:0] k;
    logic [9:0] sw;
    logic [3:0] kovr;
    logic [3:0] krdy;
    logic       sovr;
    logic       srdy;
  } state_t;

  state_t                    m;
  logic [DEBCYC:0][13:0]     hist;

  function automatic state_t model_next(input state_t s, input logic [DEBCYC:0][13:0] h,
                                        input logic we, input logic [15:0] a,
                                        input logic [15:0] wd);
    state_t     n    = s;
    logic [13:0] all1 = '1;
    logic [13:0] any1 = '0;
    logic [13:0] db   = {s.k, s.sw};
    logic [13:0] chg;
    logic [3:0]  kfall, kc_r, kc_o, kpre;
    logic        sev, sc_r, sc_o, spre;
    for (int j = 1; j <= DEBCYC; j++) begin
      all1 &= h[j];
      any1 |= h[j];
    end
    chg   = (all1 & ~db) | (~any1 & db);
    kfall = chg[13:10] & db[13:10];
    sev   = |chg[9:0];
    kc_r  = (we && a == 16'hFFF4) ? wd[3:0] : 4'h0;
    kc_o  = (we && a == 16'hFFF4) ? wd[7:4] : 4'h0;
    sc_r  = we && a == 16'hFFF6 && wd[0];
    sc_o  = we && a == 16'hFFF6 && wd[1];
    kpre  = s.krdy & ~kc_r;
    spre  = s.srdy & ~sc_r;
    n.k    = db[13:10] ^ chg[13:10];
    n.sw   = db[9:0] ^ chg[9:0];
    n.krdy = kpre | kfall;
    n.kovr = (s.kovr & ~kc_o) | (kfall & kpre);
    n.srdy = spre | sev;
    n.sovr = (s.sovr & ~sc_o) | (sev & spre);
    return n;
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m    <= {4'hF, 10'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      hist <= {(DEBCYC+1){14'h3C00}};
    end else begin
      m    <= model_next(m, hist, WE, ADDR, WRDATA);
      hist <= {hist[DEBCYC-1:0], KEY, SW};
    end
  end

  function automatic logic [15:0] exp_data(input logic [15:0] a);
    case (a)
      16'hFFF0: return {12'h0, m.k};
      16'hFFF2: return {6'h0, m.sw};
      16'hFFF4: return {8'h0, m.kovr, m.krdy};
      16'hFFF6: return {14'h0, m.sovr, m.srdy};
      default:  return 16'h0;
    endcase
  endfunction

  // Scoreboard: stimulus pushes expectations, the monitor pops and compares.
  typedef struct {
    logic [15:0] data;
    logic        hit;
    logic [15:0] addr;
    string       name;
  } exp_t;

  exp_t sb[$];
  event rd_ev;

  initial begin
    forever begin
      @(rd_ev);
      #1;
      check_head();
    end
  end

  task automatic check_head();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL monitor: read strobe with no queued expectation");
    end else begin
      e = sb.pop_front();
      if (RDDATA !== e.data || HIT !== e.hit) begin
        n_err++;
        $display("FAIL %s addr=%h: got data=%h hit=%b, expected data=%h hit=%b",
                 e.name, e.addr, RDDATA, HIT, e.data, e.hit);
      end
    end
  endtask

  task automatic issue_read(input logic [15:0] a, input logic [15:0] d, input logic h,
                            input string nm);
    exp_t e;
    e.data = d; e.hit = h; e.addr = a; e.name = nm;
    sb.push_back(e);
    ADDR = a;
    ->rd_ev;
    #2;
  endtask

  task automatic read_model(input logic [15:0] a, input string nm);
    logic h;
    h = (a == 16'hFFF0 || a == 16'hFFF2 || a == 16'hFFF4 || a == 16'hFFF6);
    issue_read(a, exp_data(a), h, nm);
  endtask

  task automatic read_const(input logic [15:0] a, input logic [15:0] d, input string nm);
    issue_read(a, d, 1'b1, nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
    @(negedge CLK);
    ADDR = a; WRDATA = d; WE = 1'b1;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] addrs [5];
    addrs = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'h1234};
    RSTN = 1'b0; ADDR = 16'h0; WRDATA = 16'h0; WE = 1'b0; KEY = 4'hF; SW = 10'h0;
    tick(3);
    RSTN = 1'b1;
    tick(2);

    // Reset / idle state and unmapped address.
    read_const(16'hFFF0, 16'h000F, "rst_kdata");
    read_const(16'hFFF2, 16'h0000, "rst_sdata");
    read_const(16'hFFF4, 16'h0000, "rst_kctrl");
    read_const(16'hFFF6, 16'h0000, "rst_sctrl");
    issue_read(16'h1234, 16'h0000, 1'b0, "unmapped");

    // KEY[2] press: accepted exactly on the sixth edge.
    @(negedge CLK); KEY[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (k == 4) begin
        read_const(16'hFFF0, 16'h000F, "key2_edge5");
        read_const(16'hFFF4, 16'h0000, "kctrl_edge5");
      end else if (k == 5) begin
        read_const(16'hFFF0, 16'h000B, "key2_edge6");
        read_const(16'hFFF4, 16'h0004, "kctrl_edge6");
      end else begin
        read_model(16'hFFF0, "key2_lat");
      end
    end

    // Three-cycle KEY[0] glitch is rejected.
    @(negedge CLK); KEY[0] = 1'b0;
    tick(3); KEY[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      read_model(16'hFFF0, "glitch_kdata");
    end
    read_const(16'hFFF0, 16'h000B, "glitch_kdata_final");
    read_const(16'hFFF4, 16'h0004, "glitch_kctrl_final");

    // Second KEY[2] press without clearing, then W1C of OVR and RDY.
    @(negedge CLK); KEY[2] = 1'b1;
    tick(8);
    KEY[2] = 1'b0;
    tick(8);
    read_const(16'hFFF4, 16'h0044, "kctrl_ovr");
    write_reg(16'hFFF4, 16'h0040);
    read_const(16'hFFF4, 16'h0004, "kctrl_clr_ovr");
    write_reg(16'hFFF4, 16'h0004);
    read_const(16'hFFF4, 16'h0000, "kctrl_clr_rdy");

    // Switch change and a second change before clear.
    @(negedge CLK); SW = 10'h2A5;
    tick(8);
    read_const(16'hFFF2, 16'h02A5, "sdata");
    read_const(16'hFFF6, 16'h0001, "sctrl_rdy");
    SW = 10'h2A4;
    tick(8);
    read_const(16'hFFF2, 16'h02A4, "sdata2");
    read_const(16'hFFF6, 16'h0003, "sctrl_ovr");

    // Press debounced on the same edge as the W1C of its RDY bit.
    write_reg(16'hFFF4, 16'hFFFF);
    @(negedge CLK); KEY[1] = 1'b0;
    tick(8);
    read_const(16'hFFF4, 16'h0002, "key1_first");
    KEY[1] = 1'b1;
    tick(8);
    KEY[1] = 1'b0;
    tick(5);
    ADDR = 16'hFFF4; WRDATA = 16'h0002; WE = 1'b1;
    @(negedge CLK); WE = 1'b0;
    read_const(16'hFFF4, 16'h0002, "same_edge_kctrl");
    write_reg(16'hFFF0, 16'hFFFF);
    read_const(16'hFFF0, 16'h0009, "kdata_write_ignored");

    // Reset mid-debounce of a KEY[3] press.
    @(negedge CLK); KEY[3] = 1'b0;
    tick(4);
    RSTN = 1'b0;
    #1;
    read_const(16'hFFF0, 16'h000F, "midrst_kdata");
    read_const(16'hFFF2, 16'h0000, "midrst_sdata");
    read_const(16'hFFF4, 16'h0000, "midrst_kctrl");
    read_const(16'hFFF6, 16'h0000, "midrst_sctrl");
    tick(2);
    RSTN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (k == 4) begin
        read_const(16'hFFF0, 16'h000F, "postrst_edge5");
        read_const(16'hFFF4, 16'h0000, "postrst_kctrl5");
      end else if (k == 5) begin
        read_const(16'hFFF0, 16'h0001, "postrst_edge6");
        read_const(16'hFFF4, 16'h000E, "postrst_kctrl6");
        read_const(16'hFFF6, 16'h0001, "postrst_sctrl6");
      end else begin
        read_model(16'hFFF2, "postrst_sdata");
      end
    end

    // Random KEY/SW activity with interleaved W1C writes and reads.
    KEY = 4'hF;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      WE = 1'b0;
      if ($urandom_range(5) == 0) begin
        int b;
        b = int'($urandom_range(3));
        KEY[b] = ~KEY[b];
      end
      if ($urandom_range(9) == 0) begin
        SW = SW ^ (10'h1 << $urandom_range(9));
      end
      read_model(addrs[$urandom_range(4)], "random_read");
      if ($urandom_range(3) == 0) begin
        ADDR   = addrs[$urandom_range(3)];
        WRDATA = 16'($urandom);
        WE     = 1'b1;
      end
    end
    @(negedge CLK); WE = 1'b0;
    tick(2);

    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
